// File: rtl/counter_mode.sv
`default_nettype none
// ---------------------------------------------------------------------------
// counter_mode : up/down modulo counter, wrap/saturate, load/clear, tc, ovf.
// Optional enable prescaler with CNT_PRESCALE_EN.   Revision: 1.0
// ---------------------------------------------------------------------------
module counter_mode #(
   parameter int cnt_WIDTH = 8,
   parameter int PRE_WIDTH = 4
) (
   input  logic                 cnt_clk,
   input  logic                 cnt_rst_n,
   input  logic                 cnt_clr,
   input  logic                 cnt_en,
   input  logic                 cnt_dir,
   input  logic                 cnt_mode,
   input  logic                 cnt_load,
   input  logic [cnt_WIDTH-1:0] cnt_load_val,
   input  logic [cnt_WIDTH-1:0] cnt_max,
   input  logic [PRE_WIDTH-1:0] cnt_pre_div,
   output logic [cnt_WIDTH-1:0] cnt_o,
   output logic                 cnt_tc_o,
   output logic                 cnt_ovf_o
);

   logic [cnt_WIDTH-1:0] cnt_q;
   logic [cnt_WIDTH-1:0] step_val;
   logic [cnt_WIDTH-1:0] load_sat;
   logic                 tc_q;
   logic                 ovf_q;
   logic                 tick;
   logic                 boundary;

`ifdef CNT_PRESCALE_EN
   logic [PRE_WIDTH-1:0] pre_q;

   assign tick = (pre_q == cnt_pre_div);

   // Prescaler only moves on enabled cycles; clear and load restart it.
   always_ff @(posedge cnt_clk or negedge cnt_rst_n) begin
      if (!cnt_rst_n) begin
         pre_q <= '0;
      end else if (cnt_clr || cnt_load) begin
         pre_q <= '0;
      end else if (cnt_en) begin
         pre_q <= tick ? '0 : pre_q + 1'b1;
      end
   end
`else
   logic unused_pre_div;

   assign tick           = 1'b1;
   assign unused_pre_div = ^cnt_pre_div;
`endif

   assign load_sat = (cnt_load_val > cnt_max) ? cnt_max : cnt_load_val;

   always_comb begin
      step_val = cnt_q;
      boundary = 1'b0;
      if (cnt_dir) begin
         if (cnt_q >= cnt_max) begin
            boundary = 1'b1;
            step_val = cnt_mode ? cnt_max : '0;
         end else begin
            step_val = cnt_q + 1'b1;
         end
      end else begin
         // Above the limit a down step snaps to the limit without flagging.
         if (cnt_q > cnt_max) begin
            step_val = cnt_max;
         end else if (cnt_q != '0) begin
            step_val = cnt_q - 1'b1;
         end else begin
            boundary = 1'b1;
            step_val = cnt_mode ? '0 : cnt_max;
         end
      end
   end

   always_ff @(posedge cnt_clk or negedge cnt_rst_n) begin
      if (!cnt_rst_n) begin
         cnt_q <= '0;
         tc_q  <= 1'b0;
         ovf_q <= 1'b0;
      end else if (cnt_clr) begin
         cnt_q <= '0;
         tc_q  <= 1'b0;
         ovf_q <= 1'b0;
      end else if (cnt_load) begin
         cnt_q <= load_sat;
         tc_q  <= 1'b0;
      end else if (cnt_en && tick) begin
         cnt_q <= step_val;
         tc_q  <= boundary;
         if (boundary) begin
            ovf_q <= 1'b1;
         end
      end else begin
         tc_q  <= 1'b0;
      end
   end

   assign cnt_o     = cnt_q;
   assign cnt_tc_o  = tc_q;
   assign cnt_ovf_o = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_counter_mode.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_counter_mode : directed scenarios plus randomized traffic vs a model.
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_counter_mode;

   localparam int W  = 8;
   localparam int PW = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          clr, en, dir, mode, load;
   logic [W-1:0]  load_val, max_v;
   logic [PW-1:0] pre_div;
   logic [W-1:0]  cnt;
   logic          tc, ovf;

   int total = 0;
   int bad   = 0;

   // reference state, plain integers
   int m_cnt, m_tc, m_ovf, m_pre;

   always #5 clk = ~clk;

   counter_mode #(.cnt_WIDTH(W), .PRE_WIDTH(PW)) dut (
      .cnt_clk      (clk),
      .cnt_rst_n    (rst_n),
      .cnt_clr      (clr),
      .cnt_en       (en),
      .cnt_dir      (dir),
      .cnt_mode     (mode),
      .cnt_load     (load),
      .cnt_load_val (load_val),
      .cnt_max      (max_v),
      .cnt_pre_div  (pre_div),
      .cnt_o        (cnt),
      .cnt_tc_o     (tc),
      .cnt_ovf_o    (ovf)
   );

   task automatic check(input string tag, input int got, input int exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0d expected=%0d at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_cnt = 0; m_tc = 0; m_ovf = 0; m_pre = 0;
   endtask

   // One rising edge worth of the behavioural rules.
   task automatic model_edge();
      int mx, tk;
      mx = int'(max_v);
`ifdef CNT_PRESCALE_EN
      tk = (m_pre == int'(pre_div));
`else
      tk = 1;
`endif
      if (clr) begin
         m_cnt = 0; m_ovf = 0; m_pre = 0; m_tc = 0;
      end else if (load) begin
         m_cnt = (int'(load_val) < mx) ? int'(load_val) : mx;
         m_pre = 0; m_tc = 0;
      end else if (en && tk) begin
         m_tc = 0;
         if (dir) begin
            if (m_cnt < mx) m_cnt = m_cnt + 1;
            else begin m_tc = 1; m_cnt = mode ? mx : 0; end
         end else begin
            if (m_cnt > mx) m_cnt = mx;
            else if (m_cnt > 0) m_cnt = m_cnt - 1;
            else begin m_tc = 1; m_cnt = mode ? 0 : mx; end
         end
         if (m_tc) m_ovf = 1;
         m_pre = 0;
      end else begin
         m_tc = 0;
         if (en) m_pre = (m_pre + 1) % (1 << PW);
      end
   endtask

   task automatic compare_all(input string tag);
      check({tag, ".cnt"}, int'(cnt), m_cnt);
      check({tag, ".tc"},  int'(tc),  m_tc);
      check({tag, ".ovf"}, int'(ovf), m_ovf);
   endtask

   // Apply current inputs for one edge, then compare #1 after it.
   task automatic cyc(input string tag);
      @(posedge clk);
      model_edge();
      #1;
      compare_all(tag);
   endtask

   task automatic idle();
      clr = 0; load = 0; en = 0;
   endtask

   initial begin
      int exp6;
      rst_n = 1'b0; clr = 0; en = 0; dir = 1; mode = 0; load = 0;
      load_val = '0; max_v = 8'hFF; pre_div = '0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      compare_all("reset");
      rst_n = 1'b1;

      // async reset mid-count
      load = 1; load_val = 8'h37; cyc("ld37");
      idle();
      check("pre_rst_cnt", int'(cnt), 'h37);
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      compare_all("async_rst");
      #1 rst_n = 1'b1;

      // wrap up-count through max=9
      @(negedge clk);
      clr = 1; cyc("clr2");
      idle(); max_v = 8'd9; dir = 1; mode = 0; en = 1;
      for (int i = 0; i < 12; i++) cyc("wrap_up");
      check("wrap_end_cnt", int'(cnt), 2);
      check("wrap_end_ovf", int'(ovf), 1);

      // saturating down-count from 2
      idle(); load = 1; load_val = 8'd2; cyc("ld2");
      idle(); dir = 0; mode = 1; en = 1;
      for (int i = 0; i < 5; i++) cyc("sat_dn");
      check("sat_dn_tc", int'(tc), 1);
      idle(); clr = 1; cyc("clr3");
      check("clr3_ovf", int'(ovf), 0);

      // clr beats load and en; load saturates to max
      clr = 1; load = 1; load_val = 8'h55; en = 1; cyc("prio");
      check("prio_cnt", int'(cnt), 0);
      idle(); max_v = 8'h20; load = 1; load_val = 8'hFF; cyc("ld_sat");
      check("ld_sat_cnt", int'(cnt), 'h20);

      // runtime max change
      idle(); max_v = 8'h40; load = 1; load_val = 8'h30; cyc("ld30");
      idle(); max_v = 8'h10; dir = 0; en = 1; cyc("snap");
      check("snap_cnt", int'(cnt), 'h10);
      check("snap_tc", int'(tc), 0);
      dir = 1; mode = 0; cyc("snap_wrap");
      check("snap_wrap_tc", int'(tc), 1);

      // prescaler ratio 3
      idle(); clr = 1; cyc("clr6");
      idle(); pre_div = 4'd2; max_v = 8'hFF; dir = 1; en = 1;
      for (int i = 0; i < 9; i++) cyc("pre");
`ifdef CNT_PRESCALE_EN
      exp6 = 3;
`else
      exp6 = 9;
`endif
      check("pre_cnt", int'(cnt), exp6);

      // max=0: every step is a boundary
      idle(); clr = 1; cyc("clr7");
      idle(); max_v = '0; pre_div = '0; en = 1; dir = 0; mode = 0;
      for (int i = 0; i < 3; i++) cyc("max0");

      // randomized traffic
      for (int i = 0; i < 600; i++) begin
         clr  = ($urandom % 25) == 0;
         load = ($urandom % 12) == 0;
         en   = ($urandom % 4) != 0;
         dir  = ($urandom % 3) != 0;
         mode = $urandom % 2;
         load_val = W'($urandom);
         if ($urandom % 10 == 0)
            max_v = ($urandom % 4 == 0) ? W'($urandom % 4) : W'($urandom);
         if ($urandom % 16 == 0) pre_div = PW'($urandom % 4);
         cyc("rand");
         if ($urandom % 60 == 0) begin
            #2 rst_n = 1'b0;
            #1;
            model_reset();
            compare_all("rand_rst");
            #1 rst_n = 1'b1;
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
